nird_joint_histogram: RTL and testbench

Joint NI/RD histogram accumulator that consumes the 4-bit rotation-invariant NI and RD code stream produced by the r2 NI-RD pipeline. Each qualified code pair increments one of BINS×BINS counters. When the frame-end pulse arrives, the block streams the completed histogram out bin by bin under a valid/ready handshake. It then self-clears for the next frame. It sits directly downstream of the NI-RD stage, ahead of the descriptor/classifier logic.

---
 rtl/nird_joint_histogram.sv | 142 ++++++++++++++
 tb/tb_nird_joint_histogram.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/nird_joint_histogram.sv
// rtl/nird_joint_histogram.sv - joint NI/RD histogram accumulator with handshaked bin readout
module nird_joint_histogram #(
  parameter int COLS      = 30,
  parameter int ROWS      = 30,
  parameter int BINS      = 10,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           ni_i,
  input  logic [3:0]           rd_i,
  input  logic                 done_i,
  input  logic                 progress_done_i,
  output logic                 ready_o,
  output logic [CNT_WIDTH-1:0] hist_o,
  output logic [6:0]           bin_idx_o,
  output logic                 hist_valid_o,
  output logic                 hist_last_o,
  input  logic                 hist_ready_i,
  output logic                 err_o
);
  localparam int         NB       = BINS * BINS;
  localparam logic [6:0] LAST_BIN = 7'(NB - 1);
  localparam logic [4:0] BINS_W   = 5'(BINS);

  if (NB > 128 || BINS > 16 || COLS < 1 || ROWS < 1) begin : g_param_check
    $error("nird_joint_histogram: unsupported geometry");
  end

  typedef enum logic [1:0] {CLEAR, ACCUM, DRAIN, READOUT} state_t;
  state_t state, state_nxt;

  logic [CNT_WIDTH-1:0] mem [NB];
  logic [6:0]           clr_cnt;
  logic                 code_ok;
  logic                 accept;
  logic                 handshake;
  logic [6:0]           acc_addr;
  logic [CNT_WIDTH-1:0] acc_rdata;
  logic                 p1_valid;
  logic [6:0]           p1_addr;
  logic [CNT_WIDTH-1:0] p1_rdata;
  logic [CNT_WIDTH-1:0] p1_wdata;
  logic [6:0]           rd_addr;
  logic [CNT_WIDTH-1:0] rd_data;

  assign code_ok   = ({1'b0, ni_i} < BINS_W) && ({1'b0, rd_i} < BINS_W);
  assign accept    = done_i && code_ok && (state == ACCUM);
  assign acc_addr  = 7'(ni_i) * 7'(BINS) + 7'(rd_i);
  assign handshake = hist_valid_o && hist_ready_i;
  assign p1_wdata  = (p1_rdata == '1) ? p1_rdata : p1_rdata + CNT_WIDTH'(1);

  // Stage 1 reads the bin; a write retiring on the same edge to the same bin is forwarded.
  always_comb begin
    acc_rdata = mem[code_ok ? acc_addr : 7'd0];
    if (p1_valid && p1_addr == acc_addr) acc_rdata = p1_wdata;
  end

  always_comb begin
    rd_addr = '0;
    if (state == READOUT && bin_idx_o != LAST_BIN) rd_addr = bin_idx_o + 7'd1;
  end

  // The DRAIN load of bin 0 can coincide with the last increment retiring.
  always_comb begin
    rd_data = mem[rd_addr];
    if (p1_valid && p1_addr == rd_addr) rd_data = p1_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CLEAR;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (clr_cnt == LAST_BIN) state_nxt = ACCUM;
      ACCUM:   if (progress_done_i) state_nxt = DRAIN;
      DRAIN:   state_nxt = READOUT;
      READOUT: if (handshake && bin_idx_o == LAST_BIN) state_nxt = CLEAR;
      default: state_nxt = CLEAR;
    endcase
  end

  always_comb begin
    ready_o = (state == ACCUM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt <= '0;
    end else if (state == CLEAR && clr_cnt != LAST_BIN) begin
      clr_cnt <= clr_cnt + 7'd1;
    end else begin
      clr_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (state == CLEAR) mem[clr_cnt] <= '0;
    else if (p1_valid)  mem[p1_addr] <= p1_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_valid <= 1'b0;
      p1_addr  <= '0;
      p1_rdata <= '0;
    end else begin
      p1_valid <= accept;
      if (accept) begin
        p1_addr  <= acc_addr;
        p1_rdata <= acc_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_o       <= '0;
      bin_idx_o    <= '0;
      hist_valid_o <= 1'b0;
      hist_last_o  <= 1'b0;
    end else if (state == DRAIN || (state == READOUT && handshake && bin_idx_o != LAST_BIN)) begin
      hist_o       <= rd_data;
      bin_idx_o    <= rd_addr;
      hist_valid_o <= 1'b1;
      hist_last_o  <= (rd_addr == LAST_BIN);
    end else if (state == READOUT && handshake) begin
      hist_o       <= '0;
      bin_idx_o    <= '0;
      hist_valid_o <= 1'b0;
      hist_last_o  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_o <= 1'b0;
    else if (done_i && (state != ACCUM || !code_ok)) err_o <= 1'b1;
  end
endmodule

// File: tb/tb_nird_joint_histogram.sv
// tb/tb_nird_joint_histogram.sv - scoreboard bench for nird_joint_histogram
module tb_nird_joint_histogram;
  localparam int NB = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  ni_i = '0;
  logic [3:0]  rd_i = '0;
  logic        done_i = 1'b0;
  logic        progress_done_i = 1'b0;
  logic        hist_ready_i = 1'b0;
  logic        ready_o, hist_valid_o, hist_last_o, err_o;
  logic [15:0] hist_o;
  logic [6:0]  bin_idx_o;
  logic        ready4, valid4, last4, err4;
  logic [3:0]  hist4;
  logic [6:0]  idx4;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int idx;
    int val;
  } exp_t;
  exp_t sb[$];
  int model [NB];

  always #5 clk = ~clk;

  nird_joint_histogram dut (
    .clk(clk), .rst_n(rst_n), .ni_i(ni_i), .rd_i(rd_i), .done_i(done_i),
    .progress_done_i(progress_done_i), .ready_o(ready_o), .hist_o(hist_o),
    .bin_idx_o(bin_idx_o), .hist_valid_o(hist_valid_o), .hist_last_o(hist_last_o),
    .hist_ready_i(hist_ready_i), .err_o(err_o)
  );

  nird_joint_histogram #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .ni_i(ni_i), .rd_i(rd_i), .done_i(done_i),
    .progress_done_i(progress_done_i), .ready_o(ready4), .hist_o(hist4),
    .bin_idx_o(idx4), .hist_valid_o(valid4), .hist_last_o(last4),
    .hist_ready_i(hist_ready_i), .err_o(err4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    done_i = 1'b0;
    progress_done_i = 1'b0;
    hist_ready_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", 32'(ready_o), 0);
    check("rst_valid", 32'(hist_valid_o), 0);
    check("rst_last", 32'(hist_last_o), 0);
    check("rst_hist", 32'(hist_o), 0);
    check("rst_idx", 32'(bin_idx_o), 0);
    check("rst_err", 32'(err_o), 0);
    check("rst_err4", 32'(err4), 0);
    rst_n = 1'b1;
    for (int i = 0; i < NB; i++) model[i] = 0;
    sb.delete();
  endtask

  task automatic wait_ready(input string tag, input bit pulse_progress);
    int cnt = 0;
    while (!ready_o && cnt < 300) begin
      progress_done_i = pulse_progress && (cnt == 5);
      @(negedge clk);
      cnt++;
    end
    progress_done_i = 1'b0;
    check(tag, 32'(cnt), 100);
    check({tag, "_4"}, 32'(ready4), 1);
  endtask

  task automatic hit(input int ni, input int rd);
    done_i = 1'b1;
    ni_i = 4'(ni);
    rd_i = 4'(rd);
    if (ni < 10 && rd < 10) model[ni * 10 + rd] += 1;
    @(negedge clk);
    done_i = 1'b0;
  endtask

  task automatic end_frame(input bit with_hit, input int ni, input int rd);
    progress_done_i = 1'b1;
    if (with_hit) begin
      done_i = 1'b1;
      ni_i = 4'(ni);
      rd_i = 4'(rd);
      model[ni * 10 + rd] += 1;
    end
    @(negedge clk);
    progress_done_i = 1'b0;
    done_i = 1'b0;
    for (int i = 0; i < NB; i++) begin
      sb.push_back('{idx: i, val: model[i]});
      model[i] = 0;
    end
    check("drain_ready", 32'(ready_o), 0);
    check("drain_valid", 32'(hist_valid_o), 0);
  endtask

  task automatic readout(input bit toggle, input int abort_at, input int inject_at);
    int budget = 0;
    int popped = 0;
    bit stalled = 1'b0;
    logic [15:0] snap_h;
    logic [6:0] snap_i;
    logic snap_l;
    exp_t e;
    ni_i = 4'd4;
    rd_i = 4'd4;
    @(negedge clk);
    check("first_valid", 32'(hist_valid_o), 1);
    check("first_idx", 32'(bin_idx_o), 0);
    while (sb.size() > 0 && budget < 1000) begin
      if (stalled) begin
        check("stall_hist", 32'(hist_o), 32'(snap_h));
        check("stall_idx", 32'(bin_idx_o), 32'(snap_i));
        check("stall_last", 32'(hist_last_o), 32'(snap_l));
        check("stall_valid", 32'(hist_valid_o), 1);
        stalled = 1'b0;
      end
      if (popped == abort_at) begin
        rst_n = 1'b0;
        sb.delete();
        break;
      end
      hist_ready_i = toggle ? (budget % 2 == 0) : 1'b1;
      done_i = (popped == inject_at);
      if (!hist_valid_o) begin
        check("readout_valid", 32'(hist_valid_o), 1);
        break;
      end
      if (hist_ready_i) begin
        e = sb.pop_front();
        check("bin_idx", 32'(bin_idx_o), 32'(e.idx));
        check("hist", 32'(hist_o), 32'(e.val));
        check("last", 32'(hist_last_o), 32'(e.idx == NB - 1));
        check("hist4", 32'(hist4), 32'(e.val > 15 ? 15 : e.val));
        check("idx4", 32'(idx4), 32'(e.idx));
        check("valid4", 32'(valid4), 1);
        check("last4", 32'(last4), 32'(e.idx == NB - 1));
        popped++;
      end else begin
        stalled = 1'b1;
        snap_h = hist_o;
        snap_i = bin_idx_o;
        snap_l = hist_last_o;
      end
      @(negedge clk);
      budget++;
    end
    hist_ready_i = 1'b0;
    done_i = 1'b0;
    check("sb_drained", 32'(sb.size()), 0);
    if (abort_at < 0) begin
      check("end_valid", 32'(hist_valid_o), 0);
      wait_ready("clear_after_readout", 1'b0);
    end
  endtask

  initial begin
    for (int i = 0; i < NB; i++) model[i] = 0;

    apply_reset();
    wait_ready("ready_after_reset", 1'b1);
    check("err_after_progress_in_clear", 32'(err_o), 0);

    for (int i = 0; i < 900; i++) hit(3, 7);
    end_frame(1'b0, 0, 0);
    readout(1'b0, -1, -1);
    check("err_clean_frame", 32'(err_o), 0);

    for (int i = 0; i < 9; i++) hit((i % 2) ? 9 : 0, (i % 2) ? 9 : 0);
    end_frame(1'b1, 9, 9);
    readout(1'b1, -1, -1);

    for (int i = 0; i < 3; i++) hit(1, 2);
    hit(12, 2);
    check("err_bad_ni", 32'(err_o), 1);
    check("err_bad_ni4", 32'(err4), 1);
    hit(2, 12);
    hit(1, 2);
    end_frame(1'b0, 0, 0);
    readout(1'b0, -1, 10);
    check("err_sticky", 32'(err_o), 1);

    apply_reset();
    wait_ready("ready_after_err_reset", 1'b0);
    for (int i = 0; i < 20; i++) hit(0, 5);
    end_frame(1'b0, 0, 0);
    readout(1'b0, 40, -1);

    apply_reset();
    wait_ready("ready_after_mid_reset", 1'b0);
    end_frame(1'b0, 0, 0);
    readout(1'b0, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
